// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - programmable interval timer with seconds prescaler and down-counter
// Holds tBASE/tEXT/tYEL, times the requested interval and pulses expired once when it elapses.
module interval_timer #(
  parameter int TICK_DIV = 100000000,
  parameter int VAL_W    = 4,
  parameter int DEF_BASE = 6,
  parameter int DEF_EXT  = 3,
  parameter int DEF_YEL  = 2
) (
  input  logic             clk,
  input  logic             Reset_Sync,
  input  logic             Prog_Sync,
  input  logic [1:0]       time_param_sel,
  input  logic [VAL_W-1:0] time_value,
  input  logic [1:0]       interval,
  input  logic             start_timer,
  output logic             expired,
  output logic             busy,
  output logic [VAL_W:0]   remaining
);

  localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [VAL_W-1:0] base_q, base_d;
  logic [VAL_W-1:0] ext_q, ext_d;
  logic [VAL_W-1:0] yel_q, yel_d;
  logic [PS_W-1:0]  psc_q, psc_d;
  logic [VAL_W:0]   count_q, count_d;
  logic             expired_q, expired_d;

  logic [VAL_W-1:0] wr_val;
  logic [VAL_W:0]   dur;
  logic             tick;

  // A programmed zero is stored as one so no interval can be zero seconds long.
  assign wr_val = (time_value == '0) ? VAL_W'(1) : time_value;

  always_comb begin
    base_d = base_q;
    ext_d  = ext_q;
    yel_d  = yel_q;
    if (Prog_Sync) begin
      case (time_param_sel)
        2'b00:   base_d = wr_val;
        2'b01:   ext_d  = wr_val;
        2'b10:   yel_d  = wr_val;
        default: ;
      endcase
    end
  end

  // Duration reads the next-state registers so a same-cycle write is seen by the start.
  always_comb begin
    dur = '0;
    case (interval)
      2'b00:   dur = {1'b0, base_d};
      2'b01:   dur = {1'b0, ext_d};
      2'b10:   dur = {1'b0, yel_d};
      default: dur = {base_d, 1'b0};
    endcase
  end

  assign tick = (state_q == S_RUN) && (psc_q == PS_MAX);

  always_comb begin
    state_d   = state_q;
    psc_d     = psc_q;
    count_d   = count_q;
    expired_d = 1'b0;
    if (start_timer) begin
      // A start always wins, including over the final tick of a running countdown.
      state_d = S_RUN;
      count_d = dur;
      psc_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          psc_d = '0;
        end
        S_RUN: begin
          if (tick) begin
            psc_d = '0;
            if (count_q > (VAL_W+1)'(1)) begin
              count_d = count_q - 1'b1;
            end else begin
              count_d   = '0;
              state_d   = S_IDLE;
              expired_d = 1'b1;
            end
          end else begin
            psc_d = psc_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset_Sync) begin
      state_q   <= S_IDLE;
      base_q    <= VAL_W'(DEF_BASE);
      ext_q     <= VAL_W'(DEF_EXT);
      yel_q     <= VAL_W'(DEF_YEL);
      psc_q     <= '0;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      ext_q     <= ext_d;
      yel_q     <= yel_d;
      psc_q     <= psc_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign expired   = expired_q;
  assign busy      = (state_q == S_RUN);
  assign remaining = count_q;

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Timing stage directly upstream of the traffic-light controller FSM. It consumes the FSM's `interval`/`start_timer` request and returns a one-cycle `expired` pulse when the requested duration has elapsed.
- Holds the three programmable time parameters (tBASE, tEXT, tYEL) and derives 2*tBASE.
- Contains the seconds prescaler and the down-counter. Remaining seconds are exported for the display.

Parameters:
- TICK_DIV, 100000000, clk cycles per one-second tick; benches use 4. Must be ≥2.
- VAL_W, 4, width of each programmable time parameter in seconds.
- DEF_BASE, 6, tBASE reset value.
- DEF_EXT, 3, tEXT reset value.
- DEF_YEL, 2, tYEL reset value.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- Reset_Sync  in  1  synchronous active-high reset, already synchronised upstream.
- Prog_Sync  in  1  synchronised program strobe, one cycle; writes `time_value` into the parameter chosen by `time_param_sel`.
- time_param_sel  in  2  00 = tBASE, 01 = tEXT, 10 = tYEL, 11 = no write.
- time_value  in  VAL_W  seconds to program.
- interval  in  2  duration select: 00 = tBASE, 01 = tEXT, 10 = tYEL, 11 = 2*tBASE.
- start_timer  in  1  start or restart request, sampled each cycle.
- expired  out  1  one-cycle pulse when the countdown completes.
- busy  out  1  countdown in progress.
- remaining  out  VAL_W+1  whole seconds left; 0 when idle.

Behaviour:
- **Reset** (Reset_Sync=1 at an edge):
  - base/ext/yel registers load DEF_BASE/DEF_EXT/DEF_YEL.
  - prescaler=0, count=0, busy=0, expired=0, remaining=0.
  - Reset dominates Prog_Sync and start_timer in the same cycle; both are ignored.
- **Programming:**
  - Prog_Sync=1 with sel≠11 writes `time_value` at that edge.
  - A `time_value` of 0 is stored as 1, so every duration is ≥1 s.
  - sel=11 writes nothing.
- **Duration lookup:** D = base, ext or yel, or {base,1'b0} for interval 11. D is zero-extended to VAL_W+1 bits; no overflow is possible (max 2*(2^VAL_W−1)).
- **Write-through:** if Prog_Sync and start_timer occur in the same cycle and the write targets the register used by `interval` (base for 00/11), D uses the newly written, 0→1 coerced value.
- **Start:** start_timer=1 at edge E0 loads count=D, prescaler=0, busy=1, expired=0.
  - This holds whether the timer was idle or busy; a restart discards the old countdown and raises no expired.
- **Prescaler:** while busy, increments every cycle. tick = busy & (prescaler==TICK_DIV−1); prescaler wraps to 0 on tick.
- **Countdown:**
  - On a tick edge with count>1: count decrements.
  - On a tick edge with count==1: count=0, busy=0, expired=1.
  - expired therefore rises at edge E0 + D*TICK_DIV and clears at the next edge.
- **Simultaneous start and final tick:** start wins. The counter reloads and expired stays 0.
- **Idle:** prescaler held at 0, no ticks, expired=0. A pulse is never produced without a preceding start.
- **remaining:** equals count, registered.
- **FSM-side assumption:** the FSM samples expired and answers with start_timer one cycle later. The one-cycle gap is accepted and is not compensated.
- **State machine:** IDLE (busy=0) and RUN (busy=1).
  - IDLE→RUN on start.
  - RUN→RUN on start or on a non-final tick.
  - RUN→IDLE on the final tick or on reset.

Test Plan:
1. **Reset defaults.** TICK_DIV=4. Reset 1 cycle, then start with interval=00 at edge E0 → expired high exactly one cycle, rising at E0+24; remaining steps 6,5,…,1 every 4 cycles; busy low after.
2. **2*tBASE and overflow bound.** Program base=15, then interval=11 → D=30, expired at E0+120; remaining never exceeds 30.
3. **Programming and zero coercion.** Program ext=0, then start with interval=01 → D=1, expired at E0+4. Program yel=9 with sel=11 → yel stays 2; interval=10 expires at E0+8.
4. **Restart mid-count.** Start D=6; at E0+10 start interval=10 → no expired near E0+24; expired at (E0+10)+8 only.
5. **Start on final tick.** Assert start in the cycle tick fires with count==1 → expired stays 0, count reloads, one pulse later at the new deadline.
6. **Reset collisions.**
   - Reset mid-count at E0+9 → busy=0, remaining=0, no expired.
   - Reset together with Prog_Sync (base=9) and start → base remains 6, timer idle.
   - Prog_Sync base=9 together with start interval=11 → expired at E0+72.
